// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap > redirect > sequential next-PC selection,
// valid/ready fetch offer and redirect epoch tag. Optional target check: PC_GEN_MISALIGN_CHECK_EN.
module pc_gen #(
  parameter int unsigned              ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]    PC_ADDR     = 32'h8000_0000,
  parameter int unsigned              INCR        = 4,
  parameter int unsigned              EPOCH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  input  logic                   trap_i,
  input  logic [ADDR_WIDTH-1:0]  trap_pc_i,
  input  logic                   halt_i,
  input  logic                   fetch_ready_i,
  output logic                   fetch_valid_o,
  output logic [ADDR_WIDTH-1:0]  fetch_pc_o,
  output logic [EPOCH_WIDTH-1:0] fetch_epoch_o,
  output logic                   halted_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic                   fire;
  logic                   target_take;
  logic [ADDR_WIDTH-1:0]  target_pc;
  logic                   mis_halt_q, mis_halt_d;
  logic                   target_misaligned;

  assign fetch_valid_o = (state_q == RUN) && !stall_i;
  assign fire          = fetch_valid_o && fetch_ready_i;
  assign target_take   = trap_i || redirect_i;
  assign target_pc     = trap_i ? trap_pc_i : redirect_pc_i;
  assign fetch_pc_o    = pc_q;
  assign fetch_epoch_o = epoch_q;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  assign target_misaligned = target_take && (target_pc[1:0] != 2'b00);

  // Sticky halt after a misaligned target; only a later trap can clear it.
  always_comb begin
    mis_halt_d = mis_halt_q;
    if (target_misaligned)
      mis_halt_d = 1'b1;
    else if (trap_i)
      mis_halt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_halt_q <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      mis_halt_q <= mis_halt_d;
      if (target_take)
        misalign_o <= target_misaligned;
    end
  end
`else
  assign target_misaligned = 1'b0;
  assign mis_halt_q        = 1'b0;
  assign mis_halt_d        = 1'b0;
  assign misalign_o        = 1'b0;
`endif

  // RUN only drops to HALTED once no offer is left dangling.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = halt_i ? HALTED : RUN;
      RUN:     if (halt_i && (!fetch_valid_o || fire)) state_d = HALTED;
      HALTED:  if (!halt_i && !mis_halt_q) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (target_misaligned)
      state_d = HALTED;
  end

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (target_take) begin
      pc_d    = target_pc;
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
    end else if (fire) begin
      pc_d    = pc_q + ADDR_WIDTH'(INCR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= PC_ADDR;
      epoch_q  <= '0;
      halted_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      halted_o <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expected values are hand-computed constants.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i, trap_i, halt_i, fetch_ready_i;
  logic [31:0] redirect_pc_i, trap_pc_i;
  logic        fetch_valid_o, halted_o, misalign_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_epoch_o;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .trap_pc_i     (trap_pc_i),
    .halt_i        (halt_i),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_epoch_o (fetch_epoch_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc,
                               input logic trap, input logic [31:0] tpc,
                               input logic halt, input logic ready);
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    trap_i        = trap;
    trap_pc_i     = tpc;
    halt_i        = halt;
    fetch_ready_i = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOffer(input string tag, input logic valid, input logic [31:0] pc, input logic [1:0] epoch);
    checkOutput({tag, ".valid"}, 32'(fetch_valid_o), 32'(valid));
    checkOutput({tag, ".pc"},    fetch_pc_o,         pc);
    checkOutput({tag, ".epoch"}, 32'(fetch_epoch_o), 32'(epoch));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    tick();
    checkOffer("reset", 0, 32'h8000_0000, 2'd0);
    checkOutput("reset.halted",   32'(halted_o),   32'd0);
    checkOutput("reset.misalign", 32'(misalign_o), 32'd0);

    // BOOT cycle then sequential stream
    reset = 1'b0;
    #1;
    checkOffer("boot", 0, 32'h8000_0000, 2'd0);
    tick();
    checkOffer("seq0", 1, 32'h8000_0000, 2'd0);
    tick();
    checkOffer("seq1", 1, 32'h8000_0004, 2'd0);
    tick();
    checkOffer("seq2", 1, 32'h8000_0008, 2'd0);

    // stall holds the PC and hides the offer
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOffer("stall0", 0, 32'h8000_0008, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOffer("stall", 0, 32'h8000_0008, 2'd0);
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOffer("resume", 1, 32'h8000_0008, 2'd0);

    // trap and redirect together: trap wins, single epoch step
    applyStimulus(0, 1, 32'h8000_0100, 1, 32'h8000_0200, 0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOffer("trap_redir", 1, 32'h8000_0200, 2'd1);

    // backpressure keeps the offer stable
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOffer("backpr", 1, 32'h8000_0200, 2'd1);
    end
    applyStimulus(0, 1, 32'h8000_0300, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOffer("redir_bp", 1, 32'h8000_0300, 2'd2);

    // address wrap
    applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
    checkOffer("top", 1, 32'hFFFF_FFFC, 2'd3);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOffer("wrap", 1, 32'h0000_0000, 2'd3);

    // epoch wraps: 3 -> 0,1,2,3
    applyStimulus(0, 1, 32'h8000_1000, 0, 32'h0, 0, 0);
    tick();
    checkOffer("ep0", 1, 32'h8000_1000, 2'd0);
    applyStimulus(0, 1, 32'h8000_1010, 0, 32'h0, 0, 0);
    tick();
    checkOffer("ep1", 1, 32'h8000_1010, 2'd1);
    applyStimulus(0, 1, 32'h8000_1020, 0, 32'h0, 0, 0);
    tick();
    checkOffer("ep2", 1, 32'h8000_1020, 2'd2);
    applyStimulus(0, 1, 32'h8000_1030, 0, 32'h0, 0, 0);
    tick();
    checkOffer("ep3", 1, 32'h8000_1030, 2'd3);

    // halt during stall, redirect while halted, release
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1, 0);
    tick();
    checkOutput("halt.halted", 32'(halted_o), 32'd1);
    applyStimulus(0, 1, 32'h8000_2000, 0, 32'h0, 1, 0);
    checkOffer("halt.nostall", 0, 32'h8000_1030, 2'd3);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0);
    checkOffer("halt.redir", 0, 32'h8000_2000, 2'd0);
    checkOutput("halt.still", 32'(halted_o), 32'd1);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    tick();
    checkOutput("release.halted", 32'(halted_o), 32'd0);
    checkOffer("release", 1, 32'h8000_2000, 2'd0);

    // misaligned redirect target
    applyStimulus(0, 1, 32'h8000_0102, 0, 32'h0, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
`ifdef PC_GEN_MISALIGN_CHECK_EN
    checkOutput("mis.flag",   32'(misalign_o), 32'd1);
    checkOutput("mis.halted", 32'(halted_o),   32'd1);
    checkOffer("mis", 0, 32'h8000_0102, 2'd1);
    tick();
    checkOutput("mis.sticky", 32'(halted_o), 32'd1);
    applyStimulus(0, 0, 32'h0, 1, 32'h8000_0400, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOutput("mis.clear", 32'(misalign_o), 32'd0);
    checkOffer("mis.trap", 0, 32'h8000_0400, 2'd2);
    tick();
    checkOutput("mis.run", 32'(halted_o), 32'd0);
    checkOffer("mis.resume", 1, 32'h8000_0400, 2'd2);
`else
    checkOutput("mis.flag",   32'(misalign_o), 32'd0);
    checkOutput("mis.halted", 32'(halted_o),   32'd0);
    checkOffer("mis", 1, 32'h8000_0102, 2'd1);
    applyStimulus(0, 0, 32'h0, 1, 32'h8000_0400, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
    checkOffer("mis.trap", 1, 32'h8000_0400, 2'd2);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
